// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory controller.
//   state_t          - controller state (INIT sweep / IDLE service)
//   ofs_bits()       - byte-offset bits inside one word
//   idx_bits()       - word-index bits for a given depth
//   ERR_MISALIGN/ERR_RANGE - error reason codes, held for a future status port
package dmem_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // Number of address bits that select a byte within a word.
  function automatic int ofs_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Number of address bits that select a word within the array.
  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: DEPTH x DATA_W storage with byte-lane write enables.
//   clk             - clock
//   rst_n           - async active-low reset (read register only, array keeps contents)
//   wr_en/wr_be     - write strobe and per-lane enables
//   wr_addr/wr_data - write word index and data
//   rd_en           - capture a read result this edge
//   rd_clr          - capture zero instead of array data (writes and errors)
//   rd_addr         - read word index
//   rd_data         - registered read result, holds between captures
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_W/8-1:0]           wr_be,
  input  logic [idx_bits(DEPTH)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  input  logic                          rd_clr,
  input  logic [idx_bits(DEPTH)-1:0]    rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_en && wr_be[b]) begin
        mem_r[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Registered read port; holds its value when no read is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= rd_clr ? {DATA_W{1'b0}} : mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory with valid/ready requests, byte
// enables, one-cycle registered responses and alignment/range checking.
// Optional macro DMEM_CLEAR_EN: zero every word after reset (busy for DEPTH
// cycles); otherwise INIT lasts one cycle and contents start undefined.
//   clk, rst_n              - clock, async active-low reset
//   req_valid/req_ready     - request handshake
//   req_we/req_addr         - write flag and byte address
//   req_wdata/req_be        - write data and byte-lane enables
//   rsp_valid/rsp_rdata     - response pulse and read data (0 on writes/errors)
//   rsp_err                 - misaligned or out-of-range request
//   busy                    - controller still in INIT
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_be,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int OFS  = ofs_bits(DATA_W);
  localparam int IDX  = idx_bits(DEPTH);
  localparam int BE_W = DATA_W / 8;
  // Mask of the in-word byte offset bits; zero when words are one byte wide.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFS) - 1);

  state_t            state_r;
  logic              ready_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;

  logic              accept_s;
  logic              misalign_s;
  logic              range_s;
  logic              err_s;
  logic [IDX-1:0]    word_idx_s;

  logic              ram_we_s;
  logic [BE_W-1:0]   ram_be_s;
  logic [IDX-1:0]    ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_rclr_s;

`ifdef DMEM_CLEAR_EN
  localparam logic [IDX-1:0] LAST_WORD = IDX'(DEPTH - 1);
  logic [IDX-1:0]    sweep_cnt_r;
`endif

  // Request decode: handshake, word index and error classification.
  always_comb begin
    accept_s   = req_valid & ready_r;
    word_idx_s = IDX'(req_addr >> OFS);
    misalign_s = (req_addr & ALIGN_MASK) != {ADDR_W{1'b0}};
    // Any address bit above the word index means the byte lies beyond DEPTH.
    range_s    = (req_addr >> (OFS + IDX)) != {ADDR_W{1'b0}};
    err_s      = misalign_s | range_s;
    // Writes and errors answer with zero data.
    ram_rclr_s = req_we | err_s;
  end

  // Write port mux: the clear sweep owns the port while in INIT.
  always_comb begin
    ram_we_s    = accept_s & req_we & ~err_s;
    ram_be_s    = req_be;
    ram_waddr_s = word_idx_s;
    ram_wdata_s = req_wdata;
`ifdef DMEM_CLEAR_EN
    if (state_r == INIT) begin
      ram_we_s    = 1'b1;
      ram_be_s    = {BE_W{1'b1}};
      ram_waddr_s = sweep_cnt_r;
      ram_wdata_s = {DATA_W{1'b0}};
    end else begin
      ram_we_s    = accept_s & req_we & ~err_s;
    end
`endif
  end

  // Controller FSM with registered ready/busy outputs and the sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT;
      ready_r     <= 1'b0;
      busy_r      <= 1'b1;
`ifdef DMEM_CLEAR_EN
      sweep_cnt_r <= {IDX{1'b0}};
`endif
    end else begin
      case (state_r)
        INIT: begin
`ifdef DMEM_CLEAR_EN
          if (sweep_cnt_r == LAST_WORD) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + IDX'(1);
          end
`else
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
`endif
        end
        IDLE: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= INIT;
          ready_r <= 1'b0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Response flags: one pulse per accepted request, error qualified by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= accept_s;
      rsp_err_r   <= accept_s & err_s;
    end
  end

  dmem_byte_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_we_s),
    .wr_be   (ram_be_s),
    .wr_addr (ram_waddr_s),
    .wr_data (ram_wdata_s),
    .rd_en   (accept_s),
    .rd_clr  (ram_rclr_s),
    .rd_addr (word_idx_s),
    .rd_data (rsp_rdata)
  );

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench for data_mem_ctrl.
// Instance A uses defaults (16-bit x 256); instance B is 32-bit x 64.
// Expectations come from a word-array model using byte-address arithmetic.
module tb_data_mem_ctrl;

`ifdef DMEM_CLEAR_EN
  localparam int SWEEP_A = 256;
  localparam int SWEEP_B = 64;
`else
  localparam int SWEEP_A = 1;
  localparam int SWEEP_B = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err, a_busy;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err, b_busy;
  logic [15:0] b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_a [256];
  logic [31:0] mem_b [64];

  data_mem_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // One request to A, issued at a negedge, response checked at the next negedge.
  task automatic req_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, input string tag);
    int a;
    logic exp_e;
    logic [15:0] exp_d;
    a = int'(addr);
    exp_e = ((a % 2) != 0) || (a >= 512);
    exp_d = 16'h0000;
    if (!exp_e) begin
      if (we) begin
        for (int b = 0; b < 2; b++) if (be[b]) mem_a[a/2][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_d = mem_a[a/2];
      end
    end
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_a: got %b expected 1", tag, a_req_ready);
    end
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    @(negedge clk);
    a_req_valid = 1'b0;
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_err !== exp_e || a_rsp_rdata !== exp_d) begin
      errors++;
      $display("FAIL %s rsp_a addr=%h: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
               tag, addr, a_rsp_valid, a_rsp_err, a_rsp_rdata, exp_e, exp_d);
    end
  endtask

  // One request to B with the same timing as req_a.
  task automatic req_b(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string tag);
    int a;
    logic exp_e;
    logic [31:0] exp_d;
    a = int'(addr);
    exp_e = ((a % 4) != 0) || (a >= 256);
    exp_d = 32'h0;
    if (!exp_e) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) mem_b[a/4][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_d = mem_b[a/4];
      end
    end
    checks++;
    if (b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_b: got %b expected 1", tag, b_req_ready);
    end
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_err !== exp_e || b_rsp_rdata !== exp_d) begin
      errors++;
      $display("FAIL %s rsp_b addr=%h: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
               tag, addr, b_rsp_valid, b_rsp_err, b_rsp_rdata, exp_e, exp_d);
    end
  endtask

  // Release reset at a negedge and count cycles with busy high on both DUTs.
  task automatic release_and_count(input string tag);
    int ca, cb;
    ca = 0; cb = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (a_busy === 1'b1) ca++;
      if (b_busy === 1'b1) cb++;
      if (a_busy !== 1'b1 && b_busy !== 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (ca != SWEEP_A || cb != SWEEP_B) begin
      errors++;
      $display("FAIL %s busy_cycles: got a=%0d b=%0d expected a=%0d b=%0d", tag, ca, cb, SWEEP_A, SWEEP_B);
    end
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after_init: got a=%b b=%b expected 1 1", tag, a_req_ready, b_req_ready);
    end
`ifdef DMEM_CLEAR_EN
    foreach (mem_a[i]) mem_a[i] = 16'h0000;
    foreach (mem_b[i]) mem_b[i] = 32'h0;
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (a_req_ready !== 1'b0 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 16'h0000 ||
        a_rsp_err !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s reset_a: got rdy=%b v=%b d=%h e=%b busy=%b expected 0 0 0000 0 1",
               tag, a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy);
    end
    checks++;
    if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0 ||
        b_rsp_err !== 1'b0 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s reset_b: got rdy=%b v=%b d=%h e=%b busy=%b expected 0 0 0 0 1",
               tag, b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    release_and_count("first_sweep");
  endtask

  task automatic test_sweep_restart();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (a_busy !== (SWEEP_A > 100)) begin
      errors++;
      $display("FAIL sweep_mid busy_a: got %b expected %b", a_busy, (SWEEP_A > 100));
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_sweep");
    @(negedge clk);
    @(negedge clk);
    release_and_count("restart_sweep");
  endtask

  // Give every word a known value when the clear sweep is not built in.
  task automatic init_model();
`ifndef DMEM_CLEAR_EN
    for (int i = 0; i < 256; i++) req_a(1'b1, 16'(i * 2), 16'h0000, 2'b11, "init_a");
    for (int i = 0; i < 64; i++) req_b(1'b1, 16'(i * 4), 32'h0, 4'b1111, "init_b");
`endif
  endtask

  task automatic test_clear_read();
    req_a(1'b0, 16'h01FE, 16'h0000, 2'b00, "clear_read");
  endtask

  task automatic test_byte_enable();
    req_a(1'b1, 16'h0010, 16'hBEEF, 2'b11, "be_wr_full");
    req_a(1'b1, 16'h0010, 16'h12AA, 2'b01, "be_wr_low");
    req_a(1'b0, 16'h0010, 16'h0000, 2'b00, "be_rd");
    req_a(1'b1, 16'h0010, 16'h7777, 2'b00, "be_noop");
    req_a(1'b0, 16'h0010, 16'h0000, 2'b11, "be_noop_rd");
    req_a(1'b1, 16'h0010, 16'h5A00, 2'b10, "be_wr_high");
    req_a(1'b0, 16'h0010, 16'h0000, 2'b00, "be_rd_high");
  endtask

  task automatic test_errors();
    req_a(1'b1, 16'h0000, 16'h5555, 2'b11, "err_prewrite");
    req_a(1'b0, 16'h0011, 16'h0000, 2'b00, "err_misalign_rd");
    req_a(1'b0, 16'h0200, 16'h0000, 2'b00, "err_range_rd");
    req_a(1'b1, 16'h0001, 16'hFFFF, 2'b11, "err_misalign_wr");
    req_a(1'b1, 16'h0200, 16'hFFFF, 2'b11, "err_range_wr");
    req_a(1'b1, 16'h8000, 16'hFFFF, 2'b11, "err_range_hi");
    req_a(1'b0, 16'h0000, 16'h0000, 2'b00, "err_unchanged");
  endtask

  task automatic test_back_to_back();
    logic [15:0] addr;
    for (int i = 0; i < 4; i++) begin
      addr = 16'($urandom_range(0, 255) * 2);
      req_a(1'b1, addr, 16'($urandom), 2'b11, "b2b_wr");
      req_a(1'b0, addr, 16'h0000, 2'($urandom), "b2b_rd");
    end
  endtask

  task automatic test_idle();
    req_a(1'b1, 16'h0020, 16'hC3A5, 2'b11, "idle_wr");
    req_a(1'b0, 16'h0020, 16'h0000, 2'b00, "idle_rd");
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 16'hC3A5) begin
      errors++;
      $display("FAIL idle_hold: got v=%b d=%h expected v=0 d=c3a5", a_rsp_valid, a_rsp_rdata);
    end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] addr;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 16'($urandom);
      else if (r == 1) addr = 16'($urandom_range(0, 300) * 2 + 1);
      else             addr = 16'($urandom_range(0, 255) * 2);
      req_a(1'($urandom), addr, 16'($urandom), 2'($urandom), "rand_a");
    end
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 16'($urandom);
      else if (r == 1) addr = 16'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else             addr = 16'($urandom_range(0, 63) * 4);
      req_b(1'($urandom), addr, $urandom, 4'($urandom), "rand_b");
    end
  endtask

  task automatic test_wide();
    req_b(1'b1, 16'h00FC, 32'h11223344, 4'b1111, "wide_last_wr");
    req_b(1'b0, 16'h00FC, 32'h0, 4'b0000, "wide_last_rd");
    req_b(1'b0, 16'h0100, 32'h0, 4'b0000, "wide_range");
    req_b(1'b1, 16'h00FE, 32'hFFFFFFFF, 4'b1111, "wide_misalign");
    req_b(1'b1, 16'h00FC, 32'hAABBCCDD, 4'b1000, "wide_be_top");
    req_b(1'b0, 16'h00FC, 32'h0, 4'b0000, "wide_be_rd");
  endtask

  // Reset arriving just after an accept edge must drop the pending response.
  task automatic test_reset_pending();
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0020; a_req_be = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_req_valid = 1'b0;
    #1;
    check_reset_vals("reset_pending");
    @(negedge clk);
    release_and_count("pending_sweep");
    init_model();
    req_a(1'b0, 16'h0010, 16'h0000, 2'b00, "post_reset_rd");
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 16'h0; a_req_wdata = 16'h0; a_req_be = 2'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 16'h0; b_req_wdata = 32'h0; b_req_be = 4'b0;
    test_reset();
    test_sweep_restart();
    init_model();
    test_clear_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_idle();
    test_wide();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised synchronous data memory for the CPU's MEM stage, replacing the fixed 256×16 array. It adds a valid/ready request port, per-byte write enables, a registered one-cycle read response, alignment and range checking, and an optional post-reset clear sweep. It sits between the load/store unit and the write-back mux.

## Interface
- DATA_W, default 16: word width in bits; must be a multiple of 8.
- DEPTH, default 256: number of words; must be a power of 2.
- ADDR_W, default 16: byte-address width; must be ≥ log2(DEPTH) + log2(DATA_W/8).
- clk  in  1  — the block's only clock; all state changes on the rising edge.
- rst_n  in  1  — reset, asynchronous and active-low.
- req_valid  in  1  — a request is presented.
- req_ready  out  1  — the block can accept a request this cycle.
- req_we  in  1  — 1 for a write, 0 for a read.
- req_addr  in  ADDR_W  — byte address.
- req_wdata  in  DATA_W  — write data.
- req_be  in  DATA_W/8  — byte-lane write enables; ignored on reads.
- rsp_valid  out  1  — one-cycle pulse marking a response.
- rsp_rdata  out  DATA_W  — read data; 0 for writes and errors.
- rsp_err  out  1  — the request was misaligned or out of range; qualified by rsp_valid.
- busy  out  1  — the clear sweep is in progress.

## Operation
- Let OFS = log2(DATA_W/8) and IDX = log2(DEPTH).
- A request is accepted when req_valid and req_ready are both high at a clk edge.
- The word index is req_addr[OFS+IDX-1 : OFS].
- A request is misaligned if req_addr[OFS-1:0] ≠ 0.
- A request is out of range if any bit of req_addr[ADDR_W-1 : OFS+IDX] is set.
- An erroring request causes no write. Its response has rsp_err=1 and rsp_rdata=0.
- Write: on the accept edge, each byte lane b with req_be[b]=1 takes req_wdata[8b+7:8b]. Lanes with req_be[b]=0 are unchanged. req_be = 0 gives a legal no-op write, with rsp_err=0.
- Read: on the accept edge, the addressed word is captured into the rsp_rdata register.
- Every accepted request, read or write, gets exactly one response.
- There is no response back-pressure. A new request may be accepted every cycle.
- FSM states: INIT, IDLE.
  - INIT → IDLE when the sweep is done (see Configuration).
  - IDLE is terminal until reset.
  - req_ready = (state == IDLE). busy = (state == INIT).
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 1. The state register resets to INIT.
- Reset asserted mid-sweep aborts the sweep. The sweep restarts from word 0 after release.
- Reset asserted while a response is pending drops that response. Memory contents are not otherwise altered by reset.

## Timing
- Read latency is 1 cycle: request accepted at edge N gives rsp_valid=1 and valid rsp_rdata from edge N until edge N+1.
- Write acknowledge latency is the same 1 cycle.
- Write at edge N, then read of the same address accepted at edge N+1: the read returns the new data.
- There is no same-edge forwarding because two requests cannot share an edge.
- When req_valid is low, rsp_valid is low the following cycle. rsp_rdata holds its last value.
- Back-to-back accepted requests give back-to-back rsp_valid pulses in request order.

## Configuration
- DMEM_CLEAR_EN defined:
  - INIT writes 0 to word k on the k-th cycle after reset release, for k = 0..DEPTH-1.
  - The FSM enters IDLE on the edge after word DEPTH-1 is written.
  - busy is high and req_ready is low for exactly DEPTH cycles.
- DMEM_CLEAR_EN undefined:
  - INIT lasts exactly one cycle after reset release; busy pulses for one cycle.
  - Memory contents are undefined until written. Simulation models initialise to X.

## Structure
- Package dmem_pkg holds:
  - the state enum typedef (INIT, IDLE);
  - helper functions for OFS and IDX;
  - the error-reason localparams (ERR_MISALIGN, ERR_RANGE), reserved for a later status port.
- Sub-module dmem_byte_ram: DEPTH×DATA_W storage with one synchronous write port carrying per-lane enables, and one synchronous read port.
- The top level keeps the FSM, the sweep counter, the address decode and the response registers.

## Test plan
- Default parameters, DMEM_CLEAR_EN defined, reset release → busy high for 256 cycles, then req_ready=1; a read of addr 0x01FE returns 0x0000.
- Write addr 0x0010, data 0xBEEF, be=2'b11, then write 0x0010, data 0x12AA, be=2'b01, then read 0x0010 → rsp_rdata=0xBEAA one cycle after the read is accepted.
- Read addr 0x0011 (misaligned) and read addr 0x0200 (out of range) → each gets rsp_valid=1, rsp_err=1, rsp_rdata=0; a prior write of 0x5555 to 0x0000 is unchanged.
- Back-to-back stream of 8 alternating write/read requests with req_valid held high → 8 consecutive rsp_valid pulses in order; each read sees the immediately preceding write.
- rst_n pulsed low at sweep cycle 100 → the sweep restarts; busy stays high for 256 cycles after the second release.
- DATA_W=32, DEPTH=64 → addr 0x00FC is the last legal word; 0x0100 gives err; be=4'b1000 writes only bits 31:24.
